// File: rtl/inter_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : inter_request_ctrl
// Brief   : Synchronises, latches and prioritises interrupt lines into one
//           interAsk/interCode request for the write-back stage.
// Revision: 1.0 - initial release
// ============================================================================
module inter_request_ctrl #(
  parameter int                   NUM_LINES   = 16,
  parameter int                   CODE_BASE   = 16,
  parameter logic [NUM_LINES-1:0] EDGE_MASK   = '1,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] irqLines,
  input  logic [NUM_LINES-1:0] irqEnable,
  input  logic                 askInterHandle,
  input  logic                 askRestartHandle,
  output logic                 interAsk,
  output logic [7:0]           interCode,
  output logic [NUM_LINES-1:0] pendingVec
);

  localparam int SEL_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ASK  = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  generate
    if (CODE_BASE < 16 || CODE_BASE + NUM_LINES > 256 || NUM_LINES < 1 ||
        NUM_LINES > 64 || SYNC_STAGES < 2) begin : g_param_err
      $error("inter_request_ctrl: illegal parameter combination");
    end
  endgenerate

  logic [SYNC_STAGES-1:0][NUM_LINES-1:0] r_sync;
  logic [NUM_LINES-1:0]                  r_hist;
  logic [NUM_LINES-1:0]                  r_pend;
  logic [SEL_W-1:0]                      r_sel;
  logic [7:0]                            r_code;
  logic                                  r_ask;
  state_t                                r_state;

  logic [NUM_LINES-1:0] w_s;
  logic [NUM_LINES-1:0] w_set;
  logic [NUM_LINES-1:0] w_cand;
  logic [NUM_LINES-1:0] w_clr;
  logic [SEL_W-1:0]     w_idx;
  logic                 w_any;
  logic                 w_retire;

  assign w_s = r_sync[SYNC_STAGES-1];
  // Level lines tap one stage earlier: the pending flop acts as their last
  // synchroniser stage, giving SYNC_STAGES cycles of raw-to-pending latency.
  assign w_set    = (EDGE_MASK & w_s & ~r_hist) | (~EDGE_MASK & r_sync[SYNC_STAGES-2]);
  assign w_cand   = r_pend & irqEnable;
  assign w_retire = (r_state == ST_ASK) && askInterHandle && !askRestartHandle;

  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_any = 1'b1;
        w_idx = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_retire) begin
      w_clr[r_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], irqLines};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist  <= '0;
      r_pend  <= '0;
      r_sel   <= '0;
      r_code  <= '0;
      r_ask   <= 1'b0;
      r_state <= ST_IDLE;
    end else if (askRestartHandle) begin
      r_hist  <= w_s;
      r_pend  <= '0;
      r_ask   <= 1'b0;
      r_state <= ST_IDLE;
    end else begin
      r_hist <= w_s;
      // Set is OR-ed after the clear so a coincident new event survives retire.
      r_pend <= (r_pend & ~w_clr) | w_set;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_sel   <= w_idx;
            r_code  <= 8'(CODE_BASE) + 8'(w_idx);
            r_ask   <= 1'b1;
            r_state <= ST_ASK;
          end
        end
        ST_ASK: begin
          if (askInterHandle) begin
            r_ask   <= 1'b0;
            r_state <= ST_BUSY;
          end else if (!irqEnable[r_sel]) begin
            r_ask   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (!askInterHandle) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ask   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign interAsk   = r_ask;
  assign interCode  = r_code;
  assign pendingVec = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_inter_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_inter_request_ctrl
// Brief   : Directed self-checking bench for inter_request_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_inter_request_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] irqLines;
  logic [15:0] irqEnable;
  logic        askInterHandle;
  logic        askRestartHandle;
  logic        interAsk;
  logic [7:0]  interCode;
  logic [15:0] pendingVec;

  int n_checks = 0;
  int n_errors = 0;

  inter_request_ctrl #(
    .NUM_LINES  (16),
    .CODE_BASE  (16),
    .EDGE_MASK  (16'hFFFE),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk             (clk),
    .rst             (rst),
    .irqLines        (irqLines),
    .irqEnable       (irqEnable),
    .askInterHandle  (askInterHandle),
    .askRestartHandle(askRestartHandle),
    .interAsk        (interAsk),
    .interCode       (interCode),
    .pendingVec      (pendingVec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [15:0] mask);
    irqLines = irqLines | mask;
    cyc(1);
    irqLines = irqLines & ~mask;
  endtask

  // Acknowledge then release; leaves time for IDLE to re-arbitrate.
  task automatic ack();
    askInterHandle = 1'b1;
    cyc(1);
    askInterHandle = 1'b0;
    cyc(2);
  endtask

  initial begin
    rst              = 1'b1;
    irqLines         = '0;
    irqEnable        = 16'hFFFF;
    askInterHandle   = 1'b0;
    askRestartHandle = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("reset_ask", {31'd0, interAsk}, 32'd0);
    chk("reset_code", {24'd0, interCode}, 32'd0);
    chk("reset_pend", {16'd0, pendingVec}, 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(2);

    // Single edge on line 3
    pulse(16'h0008);
    cyc(1);
    chk("edge_pend_early", {16'd0, pendingVec}, 32'h0);
    cyc(1);
    chk("edge_pend", {16'd0, pendingVec}, 32'h0008);
    chk("edge_ask_early", {31'd0, interAsk}, 32'd0);
    cyc(1);
    chk("edge_ask", {31'd0, interAsk}, 32'd1);
    chk("edge_code", {24'd0, interCode}, 32'd19);
    cyc(3);
    chk("edge_hold_ask", {31'd0, interAsk}, 32'd1);
    chk("edge_hold_code", {24'd0, interCode}, 32'd19);
    askInterHandle = 1'b1;
    cyc(1);
    chk("edge_retire_ask", {31'd0, interAsk}, 32'd0);
    chk("edge_retire_pend", {16'd0, pendingVec}, 32'h0);
    askInterHandle = 1'b0;
    cyc(2);
    chk("edge_idle_ask", {31'd0, interAsk}, 32'd0);

    // Priority and stability
    pulse(16'h0220);
    cyc(2);
    chk("prio_pend", {16'd0, pendingVec}, 32'h0220);
    cyc(1);
    chk("prio_ask", {31'd0, interAsk}, 32'd1);
    chk("prio_code5", {24'd0, interCode}, 32'd21);
    pulse(16'h0004);
    cyc(2);
    chk("prio_pend3", {16'd0, pendingVec}, 32'h0224);
    chk("prio_frozen", {24'd0, interCode}, 32'd21);
    askInterHandle = 1'b1;
    cyc(1);
    chk("prio_retire_ask", {31'd0, interAsk}, 32'd0);
    chk("prio_retire_pend", {16'd0, pendingVec}, 32'h0204);
    cyc(2);
    chk("prio_busy_ask", {31'd0, interAsk}, 32'd0);
    askInterHandle = 1'b0;
    cyc(2);
    chk("prio_ask2", {31'd0, interAsk}, 32'd1);
    chk("prio_code2", {24'd0, interCode}, 32'd18);
    ack();
    chk("prio_ask9", {31'd0, interAsk}, 32'd1);
    chk("prio_code9", {24'd0, interCode}, 32'd25);
    ack();
    chk("prio_done_ask", {31'd0, interAsk}, 32'd0);
    chk("prio_done_pend", {16'd0, pendingVec}, 32'h0);

    // Mask / withdraw on line 7
    pulse(16'h0080);
    cyc(3);
    chk("mask_ask", {31'd0, interAsk}, 32'd1);
    chk("mask_code", {24'd0, interCode}, 32'd23);
    irqEnable = 16'hFF7F;
    cyc(1);
    chk("mask_withdraw", {31'd0, interAsk}, 32'd0);
    chk("mask_pend", {16'd0, pendingVec}, 32'h0080);
    cyc(2);
    chk("mask_stay_idle", {31'd0, interAsk}, 32'd0);
    irqEnable = 16'hFFFF;
    cyc(1);
    chk("mask_reask", {31'd0, interAsk}, 32'd1);
    chk("mask_recode", {24'd0, interCode}, 32'd23);
    ack();
    chk("mask_done_pend", {16'd0, pendingVec}, 32'h0);

    // Level line 0
    irqLines[0] = 1'b1;
    cyc(3);
    chk("lvl_ask", {31'd0, interAsk}, 32'd1);
    chk("lvl_code", {24'd0, interCode}, 32'd16);
    askInterHandle = 1'b1;
    cyc(1);
    chk("lvl_retire_ask", {31'd0, interAsk}, 32'd0);
    askInterHandle = 1'b0;
    cyc(2);
    chk("lvl_reask", {31'd0, interAsk}, 32'd1);
    chk("lvl_recode", {24'd0, interCode}, 32'd16);
    irqLines[0] = 1'b0;
    cyc(2);
    ack();
    chk("lvl_no_second", {31'd0, interAsk}, 32'd0);
    chk("lvl_pend", {16'd0, pendingVec}, 32'h0);

    // Restart with line 1 held high, line 7 also pending
    irqLines = 16'h0082;
    cyc(1);
    irqLines = 16'h0002;
    cyc(2);
    chk("rst_pend", {16'd0, pendingVec}, 32'h0082);
    cyc(1);
    chk("rst_ask", {31'd0, interAsk}, 32'd1);
    chk("rst_code", {24'd0, interCode}, 32'd17);
    askRestartHandle = 1'b1;
    askInterHandle   = 1'b1;
    cyc(1);
    askInterHandle   = 1'b0;
    chk("rst_clr_pend", {16'd0, pendingVec}, 32'h0);
    chk("rst_clr_ask", {31'd0, interAsk}, 32'd0);
    cyc(2);
    chk("rst_blocked", {31'd0, interAsk}, 32'd0);
    askRestartHandle = 1'b0;
    cyc(4);
    chk("rst_no_spur_ask", {31'd0, interAsk}, 32'd0);
    chk("rst_no_spur_pend", {16'd0, pendingVec}, 32'h0);
    irqLines = '0;
    cyc(2);

    // Set/clear collision on line 4
    pulse(16'h0010);
    cyc(3);
    chk("coll_ask", {31'd0, interAsk}, 32'd1);
    chk("coll_code", {24'd0, interCode}, 32'd20);
    irqLines[4] = 1'b1;
    cyc(1);
    irqLines[4] = 1'b0;
    cyc(1);
    askInterHandle = 1'b1;
    cyc(1);
    chk("coll_pend", {16'd0, pendingVec}, 32'h0010);
    chk("coll_ask_drop", {31'd0, interAsk}, 32'd0);
    askInterHandle = 1'b0;
    cyc(2);
    chk("coll_reask", {31'd0, interAsk}, 32'd1);
    chk("coll_recode", {24'd0, interCode}, 32'd20);
    ack();
    chk("coll_done_pend", {16'd0, pendingVec}, 32'h0);

    // Async reset mid-ASK
    pulse(16'h0040);
    cyc(3);
    chk("areset_pre_ask", {31'd0, interAsk}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("areset_ask", {31'd0, interAsk}, 32'd0);
    chk("areset_pend", {16'd0, pendingVec}, 32'h0);
    chk("areset_code", {24'd0, interCode}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
